// File: rtl/video_scanline_fx.sv
// Scanline post-processor for the clk_vid line-buffer stream: optional 2-tap
// horizontal blend (stage 1) and per-line darkening (stage 2), fixed 2-cycle latency.
module video_scanline_fx (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  input  logic [1:0]  mode,
  input  logic [1:0]  strength,
  input  logic        blend_en,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        de_out,
  output logic [23:0] rgb_out
);

  // Handshake: none. The stream is free-running; every clk_vid cycle carries
  // one sample and every output is the input of exactly 2 cycles earlier.

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
  endfunction

  function automatic logic [7:0] darken8(input logic [7:0] c, input logic [1:0] str);
    logic [7:0] r;
    case (str)
      2'd0:    r = c - (c >> 2);
      2'd1:    r = c >> 1;
      2'd2:    r = c >> 2;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Shadow configuration, frame-scoped
  logic [1:0]  sh_mode_q, sh_mode_d;
  logic [1:0]  sh_str_q, sh_str_d;
  logic        sh_blend_q, sh_blend_d;

  // Line / frame tracking
  logic [9:0]  line_idx_q, line_idx_d;
  logic        fpar_q, fpar_d;
  logic        de_prev_q, de_prev_d;
  logic [23:0] prev_q, prev_d;

  // Stage 1
  logic        s1_vs_q, s1_vs_d;
  logic        s1_hs_q, s1_hs_d;
  logic        s1_de_q, s1_de_d;
  logic        s1_dk_q, s1_dk_d;
  logic [1:0]  s1_str_q, s1_str_d;
  logic [23:0] s1_rgb_q, s1_rgb_d;

  // Stage 2 (output registers)
  logic        vs_out_q, vs_out_d;
  logic        hs_out_q, hs_out_d;
  logic        de_out_q, de_out_d;
  logic [23:0] rgb_out_q, rgb_out_d;

  logic        de_fall;
  logic        de_rise;
  logic        dk;
  logic [23:0] blend_prev;
  logic [23:0] blended;

  always_comb begin
    sh_mode_d  = sh_mode_q;
    sh_str_d   = sh_str_q;
    sh_blend_d = sh_blend_q;
    if (vsync_in) begin
      sh_mode_d  = mode;
      sh_str_d   = strength;
      sh_blend_d = blend_en;
    end
  end

  always_comb begin
    de_fall    = de_prev_q & ~de_in;
    de_rise    = de_in & ~de_prev_q;
    de_prev_d  = de_in;
    fpar_d     = fpar_q ^ vsync_in;
    line_idx_d = line_idx_q;
    // Clear takes priority over a coincident DE falling edge
    if (vsync_in) begin
      line_idx_d = 10'd0;
    end else if (de_fall) begin
      line_idx_d = line_idx_q + 10'd1;
    end
  end

  // dk uses the pre-update line index so the falling-edge pixel stays on line k
  always_comb begin
    case (sh_mode_q)
      2'd0:    dk = 1'b0;
      2'd1:    dk = line_idx_q[0];
      2'd2:    dk = ~line_idx_q[0];
      default: dk = (line_idx_q[0] == fpar_q);
    endcase
  end

  always_comb begin
    blend_prev = de_rise ? rgb_in : prev_q;
    blended    = rgb_in;
    if (sh_blend_q) begin
      blended = {avg8(rgb_in[23:16], blend_prev[23:16]),
                 avg8(rgb_in[15:8],  blend_prev[15:8]),
                 avg8(rgb_in[7:0],   blend_prev[7:0])};
    end
    prev_d   = de_in ? rgb_in : prev_q;
    s1_vs_d  = vsync_in;
    s1_hs_d  = hsync_in;
    s1_de_d  = de_in;
    s1_dk_d  = dk & de_in;
    s1_str_d = sh_str_q;
    s1_rgb_d = de_in ? blended : rgb_in;
  end

  always_comb begin
    vs_out_d  = s1_vs_q;
    hs_out_d  = s1_hs_q;
    de_out_d  = s1_de_q;
    rgb_out_d = s1_rgb_q;
    if (s1_de_q && s1_dk_q) begin
      rgb_out_d = {darken8(s1_rgb_q[23:16], s1_str_q),
                   darken8(s1_rgb_q[15:8],  s1_str_q),
                   darken8(s1_rgb_q[7:0],   s1_str_q)};
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      sh_mode_q  <= 2'd0;
      sh_str_q   <= 2'd0;
      sh_blend_q <= 1'b0;
      line_idx_q <= 10'd0;
      fpar_q     <= 1'b0;
      de_prev_q  <= 1'b0;
      prev_q     <= 24'd0;
      s1_vs_q    <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_de_q    <= 1'b0;
      s1_dk_q    <= 1'b0;
      s1_str_q   <= 2'd0;
      s1_rgb_q   <= 24'd0;
      vs_out_q   <= 1'b0;
      hs_out_q   <= 1'b0;
      de_out_q   <= 1'b0;
      rgb_out_q  <= 24'd0;
    end else begin
      sh_mode_q  <= sh_mode_d;
      sh_str_q   <= sh_str_d;
      sh_blend_q <= sh_blend_d;
      line_idx_q <= line_idx_d;
      fpar_q     <= fpar_d;
      de_prev_q  <= de_prev_d;
      prev_q     <= prev_d;
      s1_vs_q    <= s1_vs_d;
      s1_hs_q    <= s1_hs_d;
      s1_de_q    <= s1_de_d;
      s1_dk_q    <= s1_dk_d;
      s1_str_q   <= s1_str_d;
      s1_rgb_q   <= s1_rgb_d;
      vs_out_q   <= vs_out_d;
      hs_out_q   <= hs_out_d;
      de_out_q   <= de_out_d;
      rgb_out_q  <= rgb_out_d;
    end
  end

  assign vsync_out = vs_out_q;
  assign hsync_out = hs_out_q;
  assign de_out    = de_out_q;
  assign rgb_out   = rgb_out_q;

endmodule

// File: tb/tb_video_scanline_fx.sv
// Table-driven bench for video_scanline_fx: per-cycle vectors with hand-computed
// expected pixels, compared 2 cycles later through an expected queue.
module tb_video_scanline_fx;

  logic        clk_vid = 1'b0;
  logic        reset;
  logic        vsync_in, hsync_in, de_in;
  logic [23:0] rgb_in;
  logic [1:0]  mode, strength;
  logic        blend_en;
  logic        vsync_out, hsync_out, de_out;
  logic [23:0] rgb_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] rgb;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t        vecs[$];
  logic [26:0] exp_q[$];

  video_scanline_fx dut (
    .clk_vid   (clk_vid),
    .reset     (reset),
    .vsync_in  (vsync_in),
    .hsync_in  (hsync_in),
    .de_in     (de_in),
    .rgb_in    (rgb_in),
    .mode      (mode),
    .strength  (strength),
    .blend_en  (blend_en),
    .vsync_out (vsync_out),
    .hsync_out (hsync_out),
    .de_out    (de_out),
    .rgb_out   (rgb_out)
  );

  // clock / reset
  always #5 clk_vid = ~clk_vid;

  task automatic check(input string name, input int idx, input logic [26:0] got, input logic [26:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s[%0d] got vs/hs/de/rgb=%h want %h", name, idx, got, want);
  endtask

  task automatic check_zero(input string name);
    check(name, 0, {vsync_out, hsync_out, de_out, rgb_out}, 27'd0);
  endtask

  // driver tasks
  task automatic add(input logic vs, input logic hs, input logic de,
                     input logic [23:0] rgb, input logic [23:0] exp_rgb);
    vec_t v;
    v.vs = vs; v.hs = hs; v.de = de; v.rgb = rgb; v.exp_rgb = exp_rgb;
    vecs.push_back(v);
  endtask

  task automatic add_vsync();
    add(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
  endtask

  // hsync cycle, n DE pixels, then the slot word on the first non-DE cycle
  task automatic add_line(input int n, input logic [23:0] px, input logic [23:0] exp_px,
                          input logic [23:0] slot);
    add(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b1, px, exp_px);
    add(1'b0, 1'b0, 1'b0, slot, slot);
  endtask

  task automatic run_table(input string name);
    logic [26:0] want;
    exp_q.delete();
    add(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    add(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    foreach (vecs[i]) begin
      vsync_in = vecs[i].vs;
      hsync_in = vecs[i].hs;
      de_in    = vecs[i].de;
      rgb_in   = vecs[i].rgb;
      @(posedge clk_vid);
      #1;
      exp_q.push_back({vecs[i].vs, vecs[i].hs, vecs[i].de, vecs[i].exp_rgb});
      if (exp_q.size() == 2) begin
        want = exp_q.pop_front();
        check(name, i - 1, {vsync_out, hsync_out, de_out, rgb_out}, want);
      end
    end
    vecs.delete();
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    check_zero(name);
    @(posedge clk_vid);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; vsync_in = 1'b0; hsync_in = 1'b0; de_in = 1'b0; rgb_in = 24'h0;
    mode = 2'd0; strength = 2'd0; blend_en = 1'b0;
    #2;
    do_reset("reset_state");

    // Config inputs are active but no vsync: shadows stay at reset values
    mode = 2'd2; strength = 2'd3; blend_en = 1'b1;
    add_line(256, 24'h123456, 24'h123456, 24'h000480);
    run_table("passthru");

    mode = 2'd1; strength = 2'd1; blend_en = 1'b0;
    add_vsync();
    add_line(4, 24'hFF8040, 24'hFF8040, 24'h000480);
    add_line(4, 24'hFF8040, 24'h7F4020, 24'h000481);
    add_line(4, 24'hFF8040, 24'hFF8040, 24'h000482);
    run_table("odd_dark");

    do_reset("reset_again");
    mode = 2'd3; strength = 2'd3;
    add_vsync();
    add_line(3, 24'hA5A5A5, 24'hA5A5A5, 24'h000480);
    add_line(3, 24'hA5A5A5, 24'h000000, 24'h000480);
    add_vsync();
    add_line(3, 24'h5A5A5A, 24'h000000, 24'h000480);
    add_line(3, 24'h5A5A5A, 24'h5A5A5A, 24'h000480);
    run_table("alt_frame");

    mode = 2'd0; strength = 2'd0; blend_en = 1'b1;
    add_vsync();
    add(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    add(1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000);
    add(1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'h808080);
    add(1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
    add(1'b0, 1'b0, 1'b1, 24'h101010, 24'h888888);
    add(1'b0, 1'b0, 1'b0, 24'h000480, 24'h000480);
    add(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    add(1'b0, 1'b0, 1'b1, 24'h202020, 24'h202020);
    add(1'b0, 1'b0, 1'b1, 24'h404040, 24'h303030);
    add(1'b0, 1'b0, 1'b0, 24'h000480, 24'h000480);
    run_table("blend");

    mode = 2'd0; strength = 2'd0; blend_en = 1'b0;
    add_vsync();
    add_line(2, 24'hFCFCFC, 24'hFCFCFC, 24'h000480);
    run_table("shadow_a");
    mode = 2'd1;
    add_line(2, 24'hFCFCFC, 24'hFCFCFC, 24'h000480);
    add_line(2, 24'hFCFCFC, 24'hFCFCFC, 24'h000480);
    run_table("shadow_b");
    add_vsync();
    add_line(2, 24'hFCFCFC, 24'hFCFCFC, 24'h000480);
    add_line(2, 24'hFCFCFC, 24'hBDBDBD, 24'h000480);
    run_table("shadow_c");

    // Asynchronous reset asserted in the middle of a DE run
    vsync_in = 1'b0; hsync_in = 1'b0; de_in = 1'b1; rgb_in = 24'hABCDEF;
    repeat (3) @(posedge clk_vid);
    #3;
    reset = 1'b1;
    #1;
    check_zero("reset_mid_line");
    de_in = 1'b0; rgb_in = 24'h0;
    @(posedge clk_vid);
    #2;
    reset = 1'b0;

    mode = 2'd1; strength = 2'd3;
    add_line(2, 24'h445566, 24'h445566, 24'h000480);
    add_line(2, 24'h445566, 24'h445566, 24'h000480);
    run_table("post_reset");

    // 1025 lines: line 1024 wraps to index 0 and is not darkened
    add_vsync();
    for (int k = 0; k <= 1024; k++) begin
      add(1'b0, 1'b0, 1'b1, 24'h112233, ((k % 2) == 1) ? 24'h000000 : 24'h112233);
      add(1'b0, 1'b0, 1'b0, 24'h000480, 24'h000480);
    end
    run_table("wrap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
